// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32I pipeline memory stage.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_t;

    localparam logic [3:0] BE_WORD = 4'hF;

    // One-hot byte enable for a byte access at the given lane
    function automatic logic [3:0] byte_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/memory_to_writeback.sv
// Memory->Writeback pipeline register. When not enabled it inserts a
// bubble by clearing the writeback enable; the data fields hold.
module memory_to_writeback #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               reg_write_d,
    input  logic [1:0]         result_src_d,
    input  logic [A_WIDTH-1:0] rd_d,
    input  logic [D_WIDTH-1:0] alu_result_d,
    input  logic [D_WIDTH-1:0] read_data_d,
    input  logic [D_WIDTH-1:0] pc_plus4_d,
    output logic               reg_write_q,
    output logic [1:0]         result_src_q,
    output logic [A_WIDTH-1:0] rd_q,
    output logic [D_WIDTH-1:0] alu_result_q,
    output logic [D_WIDTH-1:0] read_data_q,
    output logic [D_WIDTH-1:0] pc_plus4_q
);

    // Capture the M-stage instruction when enabled, otherwise squash it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            rd_q         <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            pc_plus4_q   <= '0;
        end else if (en) begin
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
            pc_plus4_q   <= pc_plus4_d;
        end else begin
            reg_write_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory stage of the 5-stage RV32I pipeline: req/ack data-memory port,
// byte-lane alignment, upstream stall and the M->W register.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses whose ack does
// not arrive within TIMEOUT_CYCLES request cycles (sticky mem_err).
//
//  state | meaning
//  IDLE  | no access outstanding; an access in M stalls and issues a request
//  REQ   | request driven and held stable until ack (or timeout abort)
module memory_stage
    import pipeline_pkg::*;
#(
    parameter int D_WIDTH        = 32,
    parameter int A_WIDTH        = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               RegWriteM,
    input  logic [1:0]         ResultSrcM,
    input  logic               MemWriteM,
    input  logic               ATypeM,
    input  logic [D_WIDTH-1:0] ALUResultM,
    input  logic [D_WIDTH-1:0] WriteDataM,
    input  logic [A_WIDTH-1:0] RdM,
    input  logic [D_WIDTH-1:0] PCplus4M,
    output logic               StallM,
    output logic               mem_req,
    output logic               mem_we,
    output logic [D_WIDTH-1:0] mem_addr,
    output logic [3:0]         mem_be,
    output logic [D_WIDTH-1:0] mem_wdata,
    input  logic               mem_ack,
    input  logic [D_WIDTH-1:0] mem_rdata,
    output logic               RegWriteW,
    output logic [1:0]         ResultSrcW,
    output logic [A_WIDTH-1:0] RdW,
    output logic [D_WIDTH-1:0] ALUResultW,
    output logic [D_WIDTH-1:0] ReadDataW,
    output logic [D_WIDTH-1:0] PCplus4W,
    output logic               mem_err
);

    mem_state_t         state;
    logic               access;
    logic               ack_hit;
    logic               timeout_hit;
    logic [7:0]         lane_byte;
    logic [D_WIDTH-1:0] load_aligned;
    logic [D_WIDTH-1:0] read_data_d;
    logic               reg_write_d;

    assign access  = MemWriteM | (ResultSrcM == RES_MEM);
    assign ack_hit = (state == REQ) & mem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] to_cnt;
    logic          err_q;

    assign timeout_hit = (state == REQ) & ~mem_ack & (to_cnt == TC_LAST);
    assign mem_err     = err_q;

    // Count request cycles from entry into REQ; latch a sticky abort flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE && access) begin
                to_cnt <= '0;
            end else if (state == REQ) begin
                to_cnt <= to_cnt + CW'(1);
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
    assign mem_err        = 1'b0;
`endif

    // Stall while an access waits to issue or waits for its ack
    always_comb begin
        StallM = 1'b0;
        if (state == IDLE) begin
            StallM = access;
        end else begin
            StallM = ~(ack_hit | timeout_hit);
        end
    end

    // Select and zero-extend the addressed byte lane for byte loads
    always_comb begin
        lane_byte = mem_rdata[7:0];
        case (ALUResultM[1:0])
            2'd0: lane_byte = mem_rdata[7:0];
            2'd1: lane_byte = mem_rdata[15:8];
            2'd2: lane_byte = mem_rdata[23:16];
            2'd3: lane_byte = mem_rdata[31:24];
            default: lane_byte = mem_rdata[7:0];
        endcase
        load_aligned = ATypeM ? {{(D_WIDTH-8){1'b0}}, lane_byte} : mem_rdata;
    end

    assign read_data_d = (ack_hit & ~MemWriteM) ? load_aligned : '0;
    assign reg_write_d = RegWriteM & ~timeout_hit;

    // Request FSM: issue registered request from IDLE, release on ack/abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'h0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_we   <= MemWriteM;
                        mem_addr <= {ALUResultM[D_WIDTH-1:2], 2'b00};
                        if (ATypeM) begin
                            mem_be    <= byte_be(ALUResultM[1:0]);
                            mem_wdata <= {4{WriteDataM[7:0]}};
                        end else begin
                            mem_be    <= BE_WORD;
                            mem_wdata <= WriteDataM;
                        end
                    end
                end
                REQ: begin
                    if (ack_hit | timeout_hit) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

    memory_to_writeback #(
        .D_WIDTH(D_WIDTH),
        .A_WIDTH(A_WIDTH)
    ) u_m2w (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (~StallM),
        .reg_write_d  (reg_write_d),
        .result_src_d (ResultSrcM),
        .rd_d         (RdM),
        .alu_result_d (ALUResultM),
        .read_data_d  (read_data_d),
        .pc_plus4_d   (PCplus4M),
        .reg_write_q  (RegWriteW),
        .result_src_q (ResultSrcW),
        .rd_q         (RdW),
        .alu_result_q (ALUResultW),
        .read_data_q  (ReadDataW),
        .pc_plus4_q   (PCplus4W)
    );

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU/PC+4 passthrough, word and byte
// loads, delayed-ack byte store, async reset in REQ, optional timeout.
`timescale 1ns/1ps
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic        ATypeM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCplus4M;
    logic        StallM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCplus4W;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    memory_stage #(
        .D_WIDTH(32),
        .A_WIDTH(5),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ATypeM(ATypeM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RdM(RdM), .PCplus4M(PCplus4M), .StallM(StallM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCplus4W(PCplus4W),
        .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_instr(input logic rw, input logic [1:0] rs, input logic mw,
                             input logic at, input logic [31:0] alu,
                             input logic [31:0] wd, input logic [4:0] rd,
                             input logic [31:0] pc4);
        RegWriteM  = rw;
        ResultSrcM = rs;
        MemWriteM  = mw;
        ATypeM     = at;
        ALUResultM = alu;
        WriteDataM = wd;
        RdM        = rd;
        PCplus4M   = pc4;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        set_instr(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);

        #12;
        chk("rst_req",   {31'b0, mem_req},   32'h0);
        chk("rst_we",    {31'b0, mem_we},    32'h0);
        chk("rst_be",    {28'b0, mem_be},    32'h0);
        chk("rst_addr",  mem_addr,           32'h0);
        chk("rst_wdata", mem_wdata,          32'h0);
        chk("rst_rwW",   {31'b0, RegWriteW}, 32'h0);
        chk("rst_aluW",  ALUResultW,         32'h0);
        chk("rst_err",   {31'b0, mem_err},   32'h0);

        // ALU op: no stall, 1-cycle capture, no request
        @(negedge clk);
        rst_n = 1'b1;
        set_instr(1'b1, 2'b00, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 32'h8);
        #1 chk("alu_stall", {31'b0, StallM}, 32'h0);
        @(posedge clk); #1;
        chk("alu_aluW", ALUResultW,         32'h1234);
        chk("alu_rwW",  {31'b0, RegWriteW}, 32'h1);
        chk("alu_rdW",  {27'b0, RdW},       32'd5);
        chk("alu_req",  {31'b0, mem_req},   32'h0);

        // JAL-style PC+4 result, with a stray ack in IDLE that must be ignored
        @(negedge clk);
        set_instr(1'b1, 2'b10, 1'b0, 1'b0, 32'h40, 32'h0, 5'd1, 32'h44);
        mem_ack = 1'b1;
        #1 chk("pc4_stall", {31'b0, StallM}, 32'h0);
        @(posedge clk); #1;
        chk("pc4_pcW",  PCplus4W,           32'h44);
        chk("pc4_srcW", {30'b0, ResultSrcW}, 32'h2);
        chk("pc4_req",  {31'b0, mem_req},   32'h0);

        // LW 0x100, ack in first REQ cycle
        @(negedge clk);
        mem_ack = 1'b0;
        set_instr(1'b1, 2'b01, 1'b0, 1'b0, 32'h100, 32'h0, 5'd7, 32'h48);
        #1 chk("lw_stall0", {31'b0, StallM}, 32'h1);
        @(posedge clk); #1;
        chk("lw_req",  {31'b0, mem_req},   32'h1);
        chk("lw_we",   {31'b0, mem_we},    32'h0);
        chk("lw_addr", mem_addr,           32'h100);
        chk("lw_be",   {28'b0, mem_be},    32'hF);
        chk("lw_bub",  {31'b0, RegWriteW}, 32'h0);
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        #1 chk("lw_stall1", {31'b0, StallM}, 32'h0);
        @(posedge clk); #1;
        chk("lw_reqdrop", {31'b0, mem_req},   32'h0);
        chk("lw_rdata",   ReadDataW,          32'hDEADBEEF);
        chk("lw_rwW",     {31'b0, RegWriteW}, 32'h1);
        chk("lw_rdW",     {27'b0, RdW},       32'd7);

        // LBU 0x103 -> lane 3
        @(negedge clk);
        mem_ack = 1'b0;
        set_instr(1'b1, 2'b01, 1'b0, 1'b1, 32'h103, 32'h0, 5'd9, 32'h4C);
        @(posedge clk); #1;
        chk("lbu_be",   {28'b0, mem_be}, 32'h8);
        chk("lbu_addr", mem_addr,        32'h100);
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'hAABBCCDD;
        @(posedge clk); #1;
        chk("lbu_rdata", ReadDataW, 32'h000000AA);

        // SB 0x201 data 0x55, ack in third REQ cycle
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'hFFFFFFFF;
        set_instr(1'b0, 2'b00, 1'b1, 1'b1, 32'h201, 32'h00000055, 5'd0, 32'h50);
        @(posedge clk); #1;
        chk("sb_be",    {28'b0, mem_be}, 32'h2);
        chk("sb_wdata", mem_wdata,       32'h55555555);
        chk("sb_we",    {31'b0, mem_we}, 32'h1);
        chk("sb_addr",  mem_addr,        32'h200);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk); #1;
            chk("sb_hold_stall", {31'b0, StallM}, 32'h1);
            @(posedge clk); #1;
            chk("sb_hold_req",   {31'b0, mem_req}, 32'h1);
            chk("sb_hold_be",    {28'b0, mem_be},  32'h2);
        end
        @(negedge clk);
        mem_ack = 1'b1;
        #1 chk("sb_stall_rel", {31'b0, StallM}, 32'h0);
        @(posedge clk); #1;
        chk("sb_reqdrop", {31'b0, mem_req},   32'h0);
        chk("sb_rdata0",  ReadDataW,          32'h0);
        chk("sb_rwW",     {31'b0, RegWriteW}, 32'h0);
        chk("sb_aluW",    ALUResultW,         32'h201);

        // Async reset while in REQ
        @(negedge clk);
        mem_ack = 1'b0;
        set_instr(1'b1, 2'b01, 1'b0, 1'b0, 32'h300, 32'h0, 5'd3, 32'h54);
        @(posedge clk); #1;
        chk("rr_req_pre", {31'b0, mem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_req",  {31'b0, mem_req},   32'h0);
        chk("rr_rwW",  {31'b0, RegWriteW}, 32'h0);
        chk("rr_aluW", ALUResultW,         32'h0);
        chk("rr_rdW",  ReadDataW,          32'h0);
        chk("rr_pcW",  PCplus4W,           32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_instr(1'b1, 2'b00, 1'b0, 1'b0, 32'h77, 32'h0, 5'd4, 32'h58);
        #1 chk("rr_idle_stall", {31'b0, StallM}, 32'h0);
        @(posedge clk); #1;
        chk("rr_idle_aluW", ALUResultW,       32'h77);
        chk("rr_idle_req",  {31'b0, mem_req}, 32'h0);

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after 4 REQ cycles
        @(negedge clk);
        set_instr(1'b1, 2'b01, 1'b0, 1'b0, 32'h400, 32'h0, 5'd6, 32'h5C);
        @(posedge clk); #1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); #1;
            chk("to_stall", {31'b0, StallM}, 32'h1);
            @(posedge clk); #1;
            chk("to_req",   {31'b0, mem_req}, 32'h1);
            chk("to_err0",  {31'b0, mem_err}, 32'h0);
        end
        @(negedge clk); #1;
        chk("to_stall_rel", {31'b0, StallM}, 32'h0);
        @(posedge clk); #1;
        chk("to_reqdrop", {31'b0, mem_req},   32'h0);
        chk("to_err",     {31'b0, mem_err},   32'h1);
        chk("to_rwW",     {31'b0, RegWriteW}, 32'h0);
        chk("to_rdata",   ReadDataW,          32'h0);
        @(negedge clk);
        set_instr(1'b1, 2'b00, 1'b0, 1'b0, 32'h88, 32'h0, 5'd2, 32'h60);
        @(posedge clk); #1;
        chk("to_sticky", {31'b0, mem_err}, 32'h1);
`else
        chk("err_tied0", {31'b0, mem_err}, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
